// File: rtl/key_debouncer.sv
// key_debouncer: two-flop synchroniser plus a four-state stability FSM that
// turns a bouncing, asynchronous push-button pin into a clean level with
// one-cycle press/release strobes. All outputs are registered, so the
// debounced level only moves on commit edges.
module key_debouncer #(
  parameter int   STABLE_CYCLES = 50000,
  parameter int   CNT_WIDTH     = 16,
  parameter logic IDLE_LEVEL    = 1'b1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic KeyIn,
  output logic DebounceOut,
  output logic PressPulse,
  output logic ReleasePulse
);

  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] WAIT_PRESS   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] WAIT_RELEASE = 2'd3;

  // Count value reached on the (STABLE_CYCLES-1)-th differing sample; the
  // next differing sample is the STABLE_CYCLES-th one and commits.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 r_s1;
  logic                 r_key_s;
  logic [1:0]           r_state;
  logic [1:0]           w_state_nx;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nx;
  logic                 r_out;
  logic                 w_out_nx;
  logic                 r_press;
  logic                 w_press_nx;
  logic                 r_rel;
  logic                 w_rel_nx;
  logic                 w_differs;

  assign w_differs = (r_key_s != r_out);

  // Two-flop synchroniser; resets to the released level so no false press
  // is seen while the chain refills after reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_s1    <= IDLE_LEVEL;
      r_key_s <= IDLE_LEVEL;
    end else begin
      r_s1    <= KeyIn;
      r_key_s <= r_s1;
    end
  end

  // Next-state logic: count consecutive synchronised samples that differ
  // from the current debounced level; any agreeing sample abandons the run.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_out_nx   = r_out;
    w_press_nx = 1'b0;
    w_rel_nx   = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_differs) begin
          w_state_nx = WAIT_PRESS;
          w_cnt_nx   = CNT_ONE;
        end else begin
          w_cnt_nx   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!w_differs) begin
          w_state_nx = RELEASED;
          w_cnt_nx   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nx = PRESSED;
          w_cnt_nx   = '0;
          w_out_nx   = ~IDLE_LEVEL;
          w_press_nx = 1'b1;
        end else begin
          w_cnt_nx   = r_cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (w_differs) begin
          w_state_nx = WAIT_RELEASE;
          w_cnt_nx   = CNT_ONE;
        end else begin
          w_cnt_nx   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (!w_differs) begin
          w_state_nx = PRESSED;
          w_cnt_nx   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nx = RELEASED;
          w_cnt_nx   = '0;
          w_out_nx   = IDLE_LEVEL;
          w_rel_nx   = 1'b1;
        end else begin
          w_cnt_nx   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nx = RELEASED;
        w_cnt_nx   = '0;
        w_out_nx   = IDLE_LEVEL;
      end
    endcase
  end

  // State, counter and registered outputs; reset discards any partial run.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
      r_out   <= IDLE_LEVEL;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_out   <= w_out_nx;
      r_press <= w_press_nx;
      r_rel   <= w_rel_nx;
    end
  end

  assign DebounceOut  = r_out;
  assign PressPulse   = r_press;
  assign ReleasePulse = r_rel;

endmodule

// File: tb/tb_key_debouncer.sv
// Testbench for key_debouncer: directed scenarios plus random key activity,
// with a scoreboard fed by a history-window reference model.
`timescale 1ns/1ps
module tb_key_debouncer;
  localparam int S = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic KeyIn = 1'b1;
  logic DebounceOut;
  logic PressPulse;
  logic ReleasePulse;

  key_debouncer #(
    .STABLE_CYCLES(S),
    .CNT_WIDTH(3),
    .IDLE_LEVEL(1'b1)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .KeyIn(KeyIn),
    .DebounceOut(DebounceOut),
    .PressPulse(PressPulse),
    .ReleasePulse(ReleasePulse)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;
  logic [2:0] exp_q[$];
  logic [2:0] mon_e;

  // Reference model: the pin reaches the decision point two edges late; the
  // level flips when the last S observed samples all disagree with it.
  logic m_s1, m_ks, m_out;
  logic m_hist[$];

  function automatic void model_reset();
    m_s1 = 1'b1;
    m_ks = 1'b1;
    m_out = 1'b1;
    m_hist.delete();
  endfunction

  function automatic void model_step(input logic key);
    logic press;
    logic rel;
    bit   all_diff;
    press = 1'b0;
    rel = 1'b0;
    m_hist.push_back(m_ks);
    if (m_hist.size() > S) void'(m_hist.pop_front());
    if (m_hist.size() == S) begin
      all_diff = 1'b1;
      foreach (m_hist[i]) if (m_hist[i] == m_out) all_diff = 1'b0;
      if (all_diff) begin
        m_out = ~m_out;
        press = (m_out == 1'b0);
        rel = (m_out == 1'b1);
        m_hist.delete();
      end
    end
    m_ks = m_s1;
    m_s1 = key;
    exp_q.push_back({m_out, press, rel});
  endfunction

  task automatic tick();
    @(posedge Clock);
    edge_n++;
    model_step(KeyIn);
    #2;
  endtask

  task automatic check(input string name, input logic got, input logic req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s got=%b required=%b", name, got, req);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // Drive a new level and report the relative edge at which the output moves
  // (edge 1 = first edge capturing the new level); -1 if it never moves.
  task automatic hold_measure(input string name, input logic v, input int req);
    logic old;
    int   lat;
    old = DebounceOut;
    lat = -1;
    KeyIn = v;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      tick();
      if (DebounceOut !== old) lat = k;
    end
    check_int(name, lat, req);
  endtask

  // Scoreboard monitor
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      if ({DebounceOut, PressPulse, ReleasePulse} !== mon_e) begin
        n_err++;
        if (n_err <= 30)
          $display("FAIL scoreboard edge=%0d got out/press/rel=%b required=%b",
                   edge_n, {DebounceOut, PressPulse, ReleasePulse}, mon_e);
      end
    end
  end

  initial begin
    int   np, nr, nf, nrise, last_fall, fall_edge, remaining;
    logic prev;
    logic seq [9];

    model_reset();
    repeat (3) @(posedge Clock);
    #2;
    check("reset_out", DebounceOut, 1'b1);
    check("reset_press", PressPulse, 1'b0);
    check("reset_rel", ReleasePulse, 1'b0);
    Reset = 1'b0;

    // 1: idle level held
    KeyIn = 1'b1;
    np = 0; nr = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      np += int'(PressPulse);
      nr += int'(ReleasePulse);
    end
    check("t1_out", DebounceOut, 1'b1);
    check_int("t1_pulses", np + nr, 0);

    // 2: clean press
    hold_measure("t2_press_lat", 1'b0, 6);
    check("t2_press_pulse_hi", PressPulse, 1'b1);
    tick();
    check("t2_press_pulse_lo", PressPulse, 1'b0);
    check("t2_out", DebounceOut, 1'b0);

    // 3: release, then bouncing press
    hold_measure("t3_pre_release_lat", 1'b1, 6);
    repeat (3) tick();
    seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    np = 0; last_fall = 0; fall_edge = -1;
    for (int i = 0; i < 9; i++) begin
      KeyIn = seq[i];
      tick();
      if (seq[i] == 1'b0 && (i == 0 || seq[i-1] == 1'b1)) last_fall = i + 1;
      np += int'(PressPulse);
      if (fall_edge < 0 && DebounceOut == 1'b0) fall_edge = i + 1;
    end
    for (int i = 9; i < 24; i++) begin
      tick();
      np += int'(PressPulse);
      if (fall_edge < 0 && DebounceOut == 1'b0) fall_edge = i + 1;
    end
    check_int("t3_bounce_lat", (fall_edge < 0) ? -1 : fall_edge - last_fall + 1, 6);
    check_int("t3_press_count", np, 1);

    // 4: short high glitch while pressed, then a real release
    nr = 0;
    KeyIn = 1'b1;
    repeat (3) begin tick(); nr += int'(ReleasePulse); end
    KeyIn = 1'b0;
    repeat (10) begin tick(); nr += int'(ReleasePulse); end
    check("t4_glitch_out", DebounceOut, 1'b0);
    check_int("t4_glitch_rel", nr, 0);
    hold_measure("t4_release_lat", 1'b1, 6);
    check("t4_rel_pulse_hi", ReleasePulse, 1'b1);
    tick();
    check("t4_rel_pulse_lo", ReleasePulse, 1'b0);

    // 5: asynchronous reset in the middle of a press run
    KeyIn = 1'b0;
    repeat (4) tick();
    #5;
    Reset = 1'b1;
    #1;
    check("t5_async_out", DebounceOut, 1'b1);
    check("t5_async_press", PressPulse, 1'b0);
    check("t5_async_rel", ReleasePulse, 1'b0);
    model_reset();
    #1;
    Reset = 1'b0;
    hold_measure("t5_post_reset_lat", 1'b0, 6);

    // 6: random key activity
    np = 0; nr = 0; nf = 0; nrise = 0; remaining = 0;
    prev = DebounceOut;
    for (int c = 0; c < 10000; c++) begin
      if (remaining == 0) begin
        KeyIn = 1'($urandom_range(0, 1));
        remaining = $urandom_range(1, 8);
      end
      remaining--;
      tick();
      np += int'(PressPulse);
      nr += int'(ReleasePulse);
      if (prev == 1'b1 && DebounceOut == 1'b0) nf++;
      if (prev == 1'b0 && DebounceOut == 1'b1) nrise++;
      prev = DebounceOut;
    end
    check_int("t6_press_vs_falls", np, nf);
    check_int("t6_rel_vs_rises", nr, nrise);

    #5;
    check_int("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
